instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Instruction fetch and sequencing controller that sits at the read end of the instruction memory. It drives the 5-bit `counter` address into the instruction memory and accounts for that memory's one-cycle registered read. It decodes each 16-bit `instructCode` and handles control-flow opcodes (jump, loop, halt) itself. EXEC instructions go to the autoencoder datapath through a valid/ready handshake.

## Interface
- `DATA_WIDTH`, default 16: instruction width; `[15:12]` is the opcode, `[11:0]` is the operand.
- `ADDR_WIDTH`, default 5: width of the program counter and of `counter`.
- `LOOP_WIDTH`, default 8: width of the loop counter.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse that begins execution at address 0; ignored while `busy`=1.
- `counter`  out  ADDR_WIDTH  instruction address to the instruction memory; registered.
- `instructCode`  in  DATA_WIDTH  instruction memory data; valid one cycle after `counter` is stable.
- `issue_valid`  out  1  an EXEC operand is offered to the datapath.
- `issue_ready`  in  1  the datapath accepts the operand.
- `issue_data`  out  12  EXEC operand; held stable while `issue_valid`=1.
- `busy`  out  1  high from `start` acceptance until HALT.
- `done`  out  1  high in HALTED until the next accepted `start`.
- `illegal`  out  1  sticky flag: an undefined opcode was decoded; cleared on `start`.

## Operation
- Opcodes:
  - 0 NOP
  - 1 EXEC (issue `operand[11:0]`)
  - 2 JMP (`pc` ← `operand[4:0]`)
  - 3 DJNZ (target `operand[4:0]`)
  - 4 SETCNT (`loop_cnt` ← `operand[7:0]`)
  - 15 HALT
  - 5–14 undefined: set `illegal`, execute as NOP.
- States: IDLE, FETCH, DECODE, ISSUE, HALTED.
- IDLE/HALTED + `start` → FETCH with `pc`=0. This clears `done` and `illegal`, sets `busy`, and sets `loop_cnt`=0.
- FETCH: `counter`=`pc` is held for one full cycle; the memory captures it at the closing edge. → DECODE.
- DECODE: samples `instructCode` and transitions by opcode:
  - NOP, SETCNT, undefined: `pc`+1 → FETCH.
  - JMP: target → FETCH.
  - DJNZ:
    - If `loop_cnt`=0: no decrement, `pc`+1.
    - Otherwise: `loop_cnt`−1. If the new value ≠0, jump to the target; otherwise `pc`+1.
    - In every case → FETCH.
  - EXEC: latch the operand into `issue_data`, assert `issue_valid` → ISSUE.
  - HALT: `busy`←0, `done`←1 → HALTED.
- ISSUE: hold `issue_valid`/`issue_data`. When `issue_valid`&`issue_ready` at a rising edge: drop `issue_valid`, `pc`+1 → FETCH.
- `pc`+1 from 31 wraps to 0 (modulo 2^ADDR_WIDTH).
- `loop_cnt` never underflows.
- `start` in FETCH/DECODE/ISSUE has no effect.

## Timing
- Reset (async, `rst_n`=0): state IDLE, `pc`/`counter`=0, `loop_cnt`=0, and `issue_valid`, `issue_data`, `busy`, `done`, `illegal` all 0. Reset mid-ISSUE drops `issue_valid` immediately, with no handshake.
- `start` sampled at edge k: `busy`=1 and `counter`=0 after edge k. `instructCode` is valid after edge k+1 (DECODE). A decision is registered at edge k+2.
- Non-EXEC instruction: 2 cycles (FETCH + DECODE).
- EXEC: 2 cycles + handshake wait. `issue_valid` rises after the DECODE edge; if `issue_ready` is already high, it falls after the next edge. The minimum EXEC cost is 3 cycles.
- `counter` changes only on entry to FETCH, never in DECODE/ISSUE.
- `illegal` is set at the DECODE edge and stays set until `start` or reset.

## Test plan
- Program {EXEC 0x0A5, EXEC 0x123, HALT}, `issue_ready`=1:
  - `issue_data` shows 0x0A5 then 0x123, each for exactly 1 cycle.
  - `done`=1 eight cycles after `start`; `counter` sequence 0,1,2.
- Same program with `issue_ready` held low for 5 cycles on the first EXEC:
  - `issue_valid` and 0x0A5 are stable for 6 cycles.
  - `counter` stays at 0 throughout.
- Program {SETCNT 3, EXEC 0x001, DJNZ 1, HALT}: exactly 3 EXEC handshakes, then `done`.
- Program {DJNZ 5, HALT} with `loop_cnt`=0: falls through with no jump; `done` after 4 cycles.
- JMP 31 at address 0; NOP at address 31; opcode 0x7 at address 0 on the second pass:
  - `counter` sequence 0,31,0 (wrap-around).
  - `illegal`=1 from the second DECODE of address 0.
  - A following `start` clears `illegal`.
- Assert `rst_n`=0 while in ISSUE: `issue_valid`=0 and `busy`=0 asynchronously.
  - After release, the block stays IDLE until `start`.
  - A `start` pulse while `busy`=1 is ignored (`counter` is unchanged).

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode sequencer over a registered-read instruction memory;
// resolves control flow locally and offers EXEC operands over valid/ready.
module instr_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int LOOP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] counter,
    input  logic [DATA_WIDTH-1:0] instructCode,
    output logic                  issue_valid,
    input  logic                  issue_ready,
    output logic [11:0]           issue_data,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, HALTED} state_t;
    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_EXEC   = 4'h1;
    localparam logic [3:0] OP_JMP    = 4'h2;
    localparam logic [3:0] OP_DJNZ   = 4'h3;
    localparam logic [3:0] OP_SETCNT = 4'h4;
    localparam logic [3:0] OP_HALT   = 4'hF;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [LOOP_WIDTH-1:0] loop_cnt_q, loop_cnt_d;
    logic                  issue_valid_q, issue_valid_d;
    logic [11:0]           issue_data_q, issue_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  illegal_q, illegal_d;
    logic [3:0]            opcode;
    logic [11:0]           operand;
    logic [ADDR_WIDTH-1:0] pc_inc;
    assign opcode  = instructCode[DATA_WIDTH-1 -: 4];
    assign operand = instructCode[11:0];
    assign pc_inc  = pc_q + ADDR_WIDTH'(1);
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        loop_cnt_d    = loop_cnt_q;
        issue_valid_d = issue_valid_q;
        issue_data_d  = issue_data_q;
        busy_d        = busy_q;
        done_d        = done_q;
        illegal_d     = illegal_q;
        case (state_q)
            IDLE, HALTED: if (start) begin
                state_d    = FETCH;
                pc_d       = '0;
                loop_cnt_d = '0;
                busy_d     = 1'b1;
                done_d     = 1'b0;
                illegal_d  = 1'b0;
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                state_d = FETCH;
                pc_d    = pc_inc;
                case (opcode)
                    OP_NOP:    pc_d = pc_inc;
                    OP_EXEC: begin
                        state_d       = ISSUE;
                        pc_d          = pc_q;
                        issue_valid_d = 1'b1;
                        issue_data_d  = operand;
                    end
                    OP_JMP:    pc_d = operand[ADDR_WIDTH-1:0];
                    OP_DJNZ: if (loop_cnt_q != '0) begin
                        // Jump only while the decremented count is still non-zero
                        loop_cnt_d = loop_cnt_q - LOOP_WIDTH'(1);
                        pc_d       = (loop_cnt_q != LOOP_WIDTH'(1)) ? operand[ADDR_WIDTH-1:0] : pc_inc;
                    end
                    OP_SETCNT: loop_cnt_d = operand[LOOP_WIDTH-1:0];
                    OP_HALT: begin
                        state_d = HALTED;
                        pc_d    = pc_q;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                    default:   illegal_d = 1'b1;
                endcase
            end
            ISSUE: if (issue_ready) begin
                state_d       = FETCH;
                pc_d          = pc_inc;
                issue_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            loop_cnt_q    <= '0;
            issue_valid_q <= 1'b0;
            issue_data_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            loop_cnt_q    <= loop_cnt_d;
            issue_valid_q <= issue_valid_d;
            issue_data_q  <= issue_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            illegal_q     <= illegal_d;
        end
    end
    assign counter     = pc_q;
    assign issue_valid = issue_valid_q;
    assign issue_data  = issue_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed program runs against a registered-read instruction memory model.
module tb_instr_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  counter;
    logic [15:0] instructCode = '0;
    logic        issue_valid;
    logic        issue_ready = 1'b1;
    logic [11:0] issue_data;
    logic        busy, done, illegal;
    logic [15:0] mem [32];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          hs_cnt = 0;
    int          hs_base;
    int          ev1 [9] = '{0, 0, 1, 0, 0, 1, 0, 0, 0};
    int          ec1 [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    int          ed1 [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    int          eq1 [9] = '{0, 0, 'h0A5, 0, 0, 'h123, 0, 0, 0};

    instr_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .counter(counter),
        .instructCode(instructCode), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_data(issue_data), .busy(busy), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) instructCode <= mem[counter];
    always @(posedge clk) if (rst_n && issue_valid && issue_ready) hs_cnt <= hs_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_done();
        while (!done && cyc < 200) tick();
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    endtask

    initial begin
        clear_mem();
        #12;
        chk("rst_counter", counter, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_valid", issue_valid, 0);
        chk("rst_data", issue_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // two EXECs with an always-ready datapath
        mem[0] = 16'h10A5; mem[1] = 16'h1123; mem[2] = 16'hF000;
        issue_ready = 1'b1;
        pulse_start();
        chk("t1_busy_c0", busy, 1);
        for (int c = 0; c < 9; c++) begin
            if (c > 0) tick();
            chk($sformatf("t1_valid_c%0d", c), issue_valid, ev1[c]);
            chk($sformatf("t1_counter_c%0d", c), counter, ec1[c]);
            chk($sformatf("t1_done_c%0d", c), done, ed1[c]);
            if (ev1[c] == 1) chk($sformatf("t1_data_c%0d", c), issue_data, eq1[c]);
        end
        chk("t1_busy_end", busy, 0);

        // first EXEC stalled by five not-ready cycles
        issue_ready = 1'b0;
        pulse_start();
        chk("t2_done_cleared", done, 0);
        for (int c = 0; c < 9; c++) begin
            if (c > 0) tick();
            if (c >= 2 && c <= 7) begin
                chk($sformatf("t2_valid_c%0d", c), issue_valid, 1);
                chk($sformatf("t2_data_c%0d", c), issue_data, 12'h0A5);
            end
            if (c <= 7) chk($sformatf("t2_counter_c%0d", c), counter, 0);
            if (c == 7) issue_ready = 1'b1;
        end
        chk("t2_valid_c8", issue_valid, 0);
        chk("t2_counter_c8", counter, 1);
        wait_done();
        chk("t2_done", done, 1);
        chk("t2_cycles", cyc, 13);

        // counted loop of three EXECs
        clear_mem();
        mem[0] = 16'h4003; mem[1] = 16'h1001; mem[2] = 16'h3001; mem[3] = 16'hF000;
        hs_base = hs_cnt;
        pulse_start();
        wait_done();
        chk("t3_done", done, 1);
        chk("t3_handshakes", hs_cnt - hs_base, 3);
        chk("t3_cycles", cyc, 19);
        chk("t3_counter", counter, 3);

        // DJNZ with zero count falls through
        clear_mem();
        mem[0] = 16'h3005; mem[1] = 16'hF000;
        pulse_start();
        tick(); tick();
        chk("t4_counter_c2", counter, 1);
        wait_done();
        chk("t4_done", done, 1);
        chk("t4_cycles", cyc, 4);

        // JMP 31, wrap to 0, undefined opcode on second pass
        clear_mem();
        mem[0] = 16'h201F; mem[1] = 16'hF000;
        pulse_start();
        tick(); tick();
        chk("t5_counter_c2", counter, 31);
        mem[0] = 16'h7000;
        tick(); tick();
        chk("t5_counter_c4", counter, 0);
        chk("t5_illegal_c4", illegal, 0);
        tick();
        chk("t5_illegal_c5", illegal, 0);
        tick();
        chk("t5_illegal_c6", illegal, 1);
        chk("t5_counter_c6", counter, 1);
        wait_done();
        chk("t5_done", done, 1);
        chk("t5_cycles", cyc, 8);
        chk("t5_illegal_sticky", illegal, 1);
        mem[0] = 16'hF000;
        pulse_start();
        chk("t5_illegal_cleared", illegal, 0);
        wait_done();
        chk("t5_done2", done, 1);
        chk("t5_illegal_end", illegal, 0);

        // start ignored while busy, then async reset mid-ISSUE
        clear_mem();
        mem[0] = 16'h1055; mem[1] = 16'hF000;
        issue_ready = 1'b0;
        pulse_start();
        tick(); tick();
        chk("t6_valid_c2", issue_valid, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_ignored_counter", counter, 0);
        chk("t6_ignored_valid", issue_valid, 1);
        chk("t6_ignored_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", issue_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_data", issue_data, 0);
        chk("t6_rst_counter", counter, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue_ready = 1'b1;
        tick(); tick(); tick();
        chk("t6_idle_busy", busy, 0);
        chk("t6_idle_valid", issue_valid, 0);
        chk("t6_idle_done", done, 0);
        pulse_start();
        chk("t6_restart_busy", busy, 1);
        wait_done();
        chk("t6_restart_done", done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
